gfx_writer: RTL and testbench

//  Write-side engine for the 320x200x8bpp graphics frame buffer scanned out by the VGA text/graphics generator.

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/gfx_span_clip.sv | 30 +++
 rtl/gfx_writer.sv | 169 ++++++++++++++++
 tb/tb_gfx_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared constants and encodings for the 320x200x8 graphics frame buffer.
// The VGA text/graphics generator uses the same geometry.
package gfx_pkg;

    localparam int H_RES  = 320;
    localparam int V_RES  = 200;
    localparam int ADDR_W = 16;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        OP_PLOT  = 2'd0,
        OP_FILL  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_e;

endpackage

// File: rtl/gfx_span_clip.sv
// Clips a rectangle to the visible frame and derives its first row base.
// Purely combinational; sums are one bit wider than the operands so they cannot wrap.
module gfx_span_clip
    import gfx_pkg::*;
(
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    output logic [9:0]        xe,
    output logic [8:0]        ye,
    output logic              empty,
    output logic [ADDR_W-1:0] row_base
);

    logic [9:0] x_sum;
    logic [8:0] y_sum;

    always_comb begin
        x_sum = {1'b0, x} + {1'b0, w};
        y_sum = {1'b0, y} + {1'b0, h};
        xe    = (x_sum > 10'(H_RES)) ? 10'(H_RES) : x_sum;
        ye    = (y_sum > 9'(V_RES)) ? 9'(V_RES) : y_sum;
        empty = (x >= 9'(H_RES)) || (y >= 8'(V_RES))
             || (w == '0) || (h == '0);
        // y*320 as y*256 + y*64
        row_base = (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6);
    end

endmodule

// File: rtl/gfx_writer.sv
// Write-side engine: turns PLOT/FILL/CLEAR commands into clipped,
// row-major, one-byte-per-cycle writes into the video RAM.
module gfx_writer
    import gfx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [PIX_W-1:0]  vram_data,
    output logic              busy,
    output logic              done
);

    op_e               op;
    logic [8:0]        mx;
    logic [7:0]        my;
    logic [8:0]        mw;
    logic [7:0]        mh;
    logic [9:0]        clip_xe;
    logic [8:0]        clip_ye;
    logic              clip_empty;
    logic [ADDR_W-1:0] clip_base;
    logic              cmd_empty;

    state_e            state_q, state_d;
    logic [8:0]        x0_q, x0_d;
    logic [9:0]        xe_q, xe_d;
    logic [8:0]        ye_q, ye_d;
    logic [8:0]        xc_q, xc_d;
    logic [7:0]        yc_q, yc_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic              we_q, we_d;
    logic              done_q, done_d;

    assign op = op_e'(cmd_op);

    // PLOT and CLEAR are expressed as FILL rectangles
    always_comb begin
        mx = cmd_x;
        my = cmd_y;
        mw = cmd_w;
        mh = cmd_h;
        unique case (op)
            OP_PLOT: begin
                mw = 9'd1;
                mh = 8'd1;
            end
            OP_CLEAR: begin
                mx = '0;
                my = '0;
                mw = 9'(H_RES);
                mh = 8'(V_RES);
            end
            default: ;
        endcase
    end

    gfx_span_clip u_clip (
        .x        (mx),
        .y        (my),
        .w        (mw),
        .h        (mh),
        .xe       (clip_xe),
        .ye       (clip_ye),
        .empty    (clip_empty),
        .row_base (clip_base)
    );

    assign cmd_empty = clip_empty || (op == OP_NOP);

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        xc_d       = xc_q;
        yc_d       = yc_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_WRITE;
                        we_d       = 1'b1;
                        x0_d       = mx;
                        xe_d       = clip_xe;
                        ye_d       = clip_ye;
                        xc_d       = mx;
                        yc_d       = my;
                        row_base_d = clip_base;
                        addr_d     = clip_base + ADDR_W'(mx);
                        data_d     = cmd_color;
                    end
                end
            end
            S_WRITE: begin
                if (({1'b0, xc_q} + 10'd1) < xe_q) begin
                    xc_d   = xc_q + 9'd1;
                    addr_d = addr_q + 1'b1;
                    we_d   = 1'b1;
                end else if (({1'b0, yc_q} + 9'd1) < ye_q) begin
                    yc_d       = yc_q + 8'd1;
                    xc_d       = x0_q;
                    row_base_d = row_base_q + ADDR_W'(H_RES);
                    addr_d     = row_base_q + ADDR_W'(H_RES)
                               + ADDR_W'(x0_q);
                    we_d       = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            xc_q       <= '0;
            yc_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
            xc_q       <= xc_d;
            yc_q       <= yc_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_WRITE);
    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_data = data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gfx_writer.sv
// Self-checking bench for gfx_writer: table-driven commands with a write
// scoreboard, plus back-to-back and mid-command reset sequences.
module tb_gfx_writer;

    localparam int H = 320;
    localparam int V = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd3;
    logic [8:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [7:0]  cmd_color = '0;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_data;
    logic        busy;
    logic        done;

    gfx_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        int         x;
        int         y;
        int         w;
        int         h;
        logic [7:0] c;
        int         n;
        int         first;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    wr_t sb[$];
    int wcyc[$];
    int waddr[$];
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (vram_we) begin
            wr_cnt++;
            wcyc.push_back(cyc);
            waddr.push_back(int'(vram_addr));
            check("addr_range", 32'(vram_addr <= 16'd63999), 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0d expected=none",
                         vram_addr);
            end else begin
                e = sb.pop_front();
                check("wr_addr", vram_addr, e.a);
                check("wr_data", vram_data, e.d);
            end
        end
    end

    task automatic push_exp(input logic [1:0] op, input int x, input int y,
                            input int w, input int h, input logic [7:0] c);
        int xs, ys, ww, hh, xe, ye;
        wr_t e;
        xs = x; ys = y; ww = w; hh = h;
        if (op == 2'd0) begin ww = 1; hh = 1; end
        if (op == 2'd2) begin xs = 0; ys = 0; ww = H; hh = V; end
        if (op == 2'd3) return;
        if (xs >= H || ys >= V || ww == 0 || hh == 0) return;
        xe = (xs + ww > H) ? H : xs + ww;
        ye = (ys + hh > V) ? V : ys + hh;
        for (int yy = ys; yy < ye; yy++)
            for (int xx = xs; xx < xe; xx++) begin
                e.a = 16'(xx + yy * H);
                e.d = c;
                sb.push_back(e);
            end
    endtask

    task automatic drive(input logic [1:0] op, input int x, input int y,
                         input int w, input int h, input logic [7:0] c);
        cmd_op = op;
        cmd_x = 9'(x);
        cmd_y = 8'(y);
        cmd_w = 9'(w);
        cmd_h = 8'(h);
        cmd_color = c;
    endtask

    task automatic run(input vec_t v);
        int acc, d0, w0, b0, k;
        push_exp(v.op, v.x, v.y, v.w, v.h, v.c);
        wcyc.delete();
        waddr.delete();
        d0 = done_cnt;
        w0 = wr_cnt;
        b0 = busy_cnt;
        @(negedge clk);
        #1;
        check({v.name, "_ready"}, 32'(cmd_ready), 1);
        drive(v.op, v.x, v.y, v.w, v.h, v.c);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < v.n + 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({v.name, "_done_seen"}, 32'(done_cnt - d0), 1);
        check({v.name, "_done_cyc"}, done_cyc, acc + v.n);
        check({v.name, "_writes"}, wr_cnt - w0, v.n);
        check({v.name, "_busy"}, busy_cnt - b0, v.n);
        if (v.n > 0 && waddr.size() > 0) begin
            check({v.name, "_first_addr"}, waddr[0], v.first);
            check({v.name, "_first_cyc"}, wcyc[0], acc);
        end
        check({v.name, "_sb_left"}, sb.size(), 0);
        sb.delete();
        @(negedge clk);
        #1;
        check({v.name, "_done_pulse"}, done_cnt - d0, 1);
        check({v.name, "_we_idle"}, 32'(vram_we), 0);
    endtask

    initial begin
        int k, w0, d0;
        vec_t cl;

        vecs[0] = '{"plot", 2'd0, 10, 5, 0, 0, 8'h3C, 1, 1610};
        vecs[1] = '{"fill_clip", 2'd1, 318, 198, 5, 4, 8'hA5, 4, 63678};
        vecs[2] = '{"fill_w0", 2'd1, 0, 0, 0, 5, 8'h12, 0, 0};
        vecs[3] = '{"plot_x320", 2'd0, 320, 0, 0, 0, 8'h34, 0, 0};
        vecs[4] = '{"nop", 2'd3, 1, 1, 4, 4, 8'h56, 0, 0};
        vecs[5] = '{"fill_7x3", 2'd1, 100, 50, 7, 3, 8'h11, 21, 16100};
        vecs[6] = '{"plot_corner", 2'd0, 319, 199, 0, 0, 8'hFF, 1, 63999};
        vecs[7] = '{"fill_yclip", 2'd1, 5, 199, 4, 9, 8'h22, 4, 63685};
        vecs[8] = '{"fill_y200", 2'd1, 0, 200, 4, 4, 8'h33, 0, 0};
        vecs[9] = '{"fill_big", 2'd1, 300, 10, 511, 255, 8'h99, 3800, 3500};

        #1;
        check("rst_we", 32'(vram_we), 0);
        check("rst_addr", vram_addr, 0);
        check("rst_data", vram_data, 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run(vecs[i]);

        cl = '{"clear", 2'd2, 7, 7, 1, 1, 8'h00, 64000, 0};
        run(cl);

        // back-to-back: FILL then PLOT with cmd_valid held high
        push_exp(2'd1, 2, 3, 3, 1, 8'h44);
        push_exp(2'd0, 7, 8, 0, 0, 8'h55);
        wcyc.delete();
        waddr.delete();
        d0 = done_cnt;
        @(negedge clk);
        drive(2'd1, 2, 3, 3, 1, 8'h44);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(2'd0, 7, 8, 0, 0, 8'h55);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(cmd_ready && done) && k < 20);
        check("b2b_fill_done", 32'(cmd_ready && done), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while (done_cnt < d0 + 2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("b2b_dones", done_cnt - d0, 2);
        check("b2b_writes", wcyc.size(), 4);
        if (wcyc.size() == 4) begin
            check("b2b_fill_run", wcyc[2] - wcyc[0], 2);
            check("b2b_gap", wcyc[3] - wcyc[2], 2);
            check("b2b_plot_addr", waddr[3], 2567);
        end
        check("b2b_sb_left", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);

        // reset in the middle of a CLEAR, right after write #100
        push_exp(2'd2, 0, 0, 0, 0, 8'h77);
        w0 = wr_cnt;
        @(negedge clk);
        drive(2'd2, 0, 0, 0, 0, 8'h77);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while (wr_cnt - w0 < 100 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("mid_writes", wr_cnt - w0, 100);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_we", 32'(vram_we), 0);
        check("mid_rst_addr", vram_addr, 0);
        check("mid_rst_data", vram_data, 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("mid_no_more", wr_cnt - w0, 100);
        vecs[0].name = "plot_after_rst";
        run(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
